// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for three masters: serial slave-select frame,
// slave busy check, then a grant bounded by done, request drop or timeout.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned SLAVE_ID_WIDTH = 2,
  parameter logic [7:0]  TIMEOUT        = 8'd255
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [NUM_MASTERS-1:0]                m_req,
  input  logic [NUM_MASTERS*SLAVE_ID_WIDTH-1:0] m_slave_id,
  input  logic [NUM_MASTERS-1:0]                m_done,
  input  logic [NUM_SLAVES-1:0]                 slave_busy,
  output logic [NUM_MASTERS-1:0]                m_grant,
  output logic                                  bus_util,
  output logic                                  arbiter_cmd_out,
  output logic [1:0]                            cur_master,
  output logic                                  timeout_pulse,
  output logic                                  reject_pulse
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_CHECK   = 3'd2,
    S_GRANT   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [SLAVE_ID_WIDTH:0] LP_NUM_SLAVES = (SLAVE_ID_WIDTH+1)'(NUM_SLAVES);
  localparam logic [3:0]              LP_LAST_BIT   = 4'(SLAVE_ID_WIDTH);
  localparam logic [1:0]              LP_LAST_MST   = 2'(NUM_MASTERS - 1);

  state_t                    r_state, w_state_nxt;
  logic [1:0]                r_cur, w_cur_nxt;
  logic [1:0]                r_last, w_last_nxt;
  logic [SLAVE_ID_WIDTH-1:0] r_id, w_id_nxt;
  logic [SLAVE_ID_WIDTH:0]   r_frame, w_frame_nxt;
  logic [3:0]                r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]                r_cnt, w_cnt_nxt;
  logic [NUM_MASTERS-1:0]    r_grant, w_grant_nxt;
  logic                      r_util, r_cmd, w_cmd_nxt;
  logic                      r_tmo, w_tmo_nxt;
  logic                      r_rej, w_rej_nxt;

  logic                      w_pick_vld;
  logic [1:0]                w_pick;
  logic [SLAVE_ID_WIDTH-1:0] w_pick_id;
  logic                      w_cur_done, w_cur_req, w_hold_tmo;

  // Scan from farthest to nearest so the nearest requester after last_served wins.
  always_comb begin
    logic [1:0] v_idx;
    v_idx      = '0;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int unsigned i = NUM_MASTERS; i > 0; i--) begin
      v_idx = 2'((32'(r_last) + i) % NUM_MASTERS);
      if (m_req[v_idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = v_idx;
      end
    end
  end

  assign w_pick_id  = m_slave_id[w_pick*SLAVE_ID_WIDTH +: SLAVE_ID_WIDTH];
  assign w_cur_done = m_done[r_cur];
  assign w_cur_req  = m_req[r_cur];
  // The first GRANT cycle only arms the grant register, so the hold
  // counter is compared only once the grant is visible.
  assign w_hold_tmo = r_util && (r_cnt == TIMEOUT - 8'd1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_last_nxt    = r_last;
    w_id_nxt      = r_id;
    w_frame_nxt   = r_frame;
    w_bit_cnt_nxt = r_bit_cnt;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = '0;
    w_cmd_nxt     = 1'b0;
    w_tmo_nxt     = 1'b0;
    w_rej_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_cur_nxt = w_pick;
          w_id_nxt  = w_pick_id;
          if ({1'b0, w_pick_id} >= LP_NUM_SLAVES) begin
            w_rej_nxt  = 1'b1;
            w_last_nxt = w_pick;
          end else begin
            w_state_nxt   = S_SEND;
            w_frame_nxt   = {1'b1, w_pick_id};
            w_bit_cnt_nxt = '0;
          end
        end
      end
      S_SEND: begin
        w_cmd_nxt     = r_frame[SLAVE_ID_WIDTH];
        w_frame_nxt   = {r_frame[SLAVE_ID_WIDTH-1:0], 1'b0};
        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        if (r_bit_cnt == LP_LAST_BIT) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!w_cur_req) begin
          w_state_nxt = S_IDLE;
        end else if (slave_busy[r_id]) begin
          w_rej_nxt   = 1'b1;
          w_last_nxt  = r_cur;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_cur_done || !w_cur_req || w_hold_tmo) begin
          w_tmo_nxt   = w_hold_tmo && !w_cur_done;
          w_state_nxt = S_RELEASE;
        end else begin
          w_grant_nxt[r_cur] = 1'b1;
          if (r_util) begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      S_RELEASE: begin
        w_last_nxt  = r_cur;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_last    <= LP_LAST_MST;
      r_id      <= '0;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_util    <= 1'b0;
      r_cmd     <= 1'b0;
      r_tmo     <= 1'b0;
      r_rej     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
      r_id      <= w_id_nxt;
      r_frame   <= w_frame_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_util    <= |w_grant_nxt;
      r_cmd     <= w_cmd_nxt;
      r_tmo     <= w_tmo_nxt;
      r_rej     <= w_rej_nxt;
    end
  end

  assign m_grant         = r_grant;
  assign bus_util        = r_util;
  assign arbiter_cmd_out = r_cmd;
  assign cur_master      = r_cur;
  assign timeout_pulse   = r_tmo;
  assign reject_pulse    = r_rej;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus
// random traffic checked every cycle against an offset-based reference model.
module tb_bus_arbiter;

  localparam int unsigned TMO = 8;

  logic       clk;
  logic       rstn;
  logic [2:0] m_req;
  logic [5:0] m_slave_id;
  logic [2:0] m_done;
  logic [2:0] slave_busy;
  logic [2:0] m_grant;
  logic       bus_util;
  logic       arbiter_cmd_out;
  logic [1:0] cur_master;
  logic       timeout_pulse;
  logic       reject_pulse;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bus_arbiter #(
    .NUM_MASTERS   (3),
    .NUM_SLAVES    (3),
    .SLAVE_ID_WIDTH(2),
    .TIMEOUT       (8'd8)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .m_req          (m_req),
    .m_slave_id     (m_slave_id),
    .m_done         (m_done),
    .slave_busy     (slave_busy),
    .m_grant        (m_grant),
    .bus_util       (bus_util),
    .arbiter_cmd_out(arbiter_cmd_out),
    .cur_master     (cur_master),
    .timeout_pulse  (timeout_pulse),
    .reject_pulse   (reject_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({m_grant, bus_util, arbiter_cmd_out, cur_master, timeout_pulse, reject_pulse});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: tracks a transaction by edge offset from the arbitration
  // edge and predicts the outputs visible after each rising edge.
  logic [2:0]  e_grant = '0;
  logic        e_util  = 1'b0;
  logic        e_cmd   = 1'b0;
  logic [1:0]  e_cur   = '0;
  logic        e_tmo   = 1'b0;
  logic        e_rej   = 1'b0;
  int unsigned md_ls   = 2;
  int unsigned md_off  = 0;
  int unsigned md_vis  = 0;
  bit          md_busy = 1'b0;
  bit          md_rel  = 1'b0;
  logic [1:0]  md_id   = '0;
  logic [2:0]  md_gprev;
  logic [2:0]  md_fr;
  logic [1:0]  md_j, md_bi;
  bit          md_found, md_tmo;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        e_grant = '0; e_util = 1'b0; e_cmd = 1'b0; e_cur = '0; e_tmo = 1'b0; e_rej = 1'b0;
        md_ls = 2; md_busy = 1'b0; md_rel = 1'b0; md_off = 0; md_vis = 0;
      end else begin
        md_gprev = e_grant;
        e_grant  = '0;
        e_cmd    = 1'b0;
        e_tmo    = 1'b0;
        e_rej    = 1'b0;
        if (md_rel) begin
          md_rel  = 1'b0;
          md_busy = 1'b0;
          md_ls   = 32'(e_cur);
        end else if (!md_busy) begin
          md_found = 1'b0;
          for (int unsigned d = 1; d <= 3; d++) begin
            md_j = 2'((md_ls + d) % 3);
            if (!md_found && m_req[md_j]) begin
              md_found = 1'b1;
              e_cur    = md_j;
              md_id    = m_slave_id[2*md_j +: 2];
            end
          end
          if (md_found) begin
            if (md_id >= 2'd3) begin
              e_rej = 1'b1;
              md_ls = 32'(e_cur);
            end else begin
              md_busy = 1'b1;
              md_off  = 0;
            end
          end
        end else begin
          md_off++;
          if (md_off <= 3) begin
            md_fr = {1'b1, md_id};
            md_bi = 2'(3 - md_off);
            e_cmd = md_fr[md_bi];
          end else if (md_off == 4) begin
            if (!m_req[e_cur]) begin
              md_busy = 1'b0;
            end else if (slave_busy[md_id]) begin
              e_rej   = 1'b1;
              md_ls   = 32'(e_cur);
              md_busy = 1'b0;
            end else begin
              md_vis = 0;
            end
          end else begin
            if (md_gprev != 3'b000) md_vis++;
            md_tmo = (md_gprev != 3'b000) && (md_vis == TMO);
            if (m_done[e_cur] || !m_req[e_cur] || md_tmo) begin
              md_rel = 1'b1;
              e_tmo  = md_tmo && !m_done[e_cur];
            end else begin
              e_grant = 3'b001 << e_cur;
            end
          end
        end
        e_util = |e_grant;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cycle", dut_vec(), 32'({e_grant, e_util, e_cmd, e_cur, e_tmo, e_rej}));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int unsigned cnt, n, ng, gcnt;
  logic [2:0]  prev_g;
  logic [2:0]  order [0:3];

  initial begin
    rstn = 1'b1; m_req = '0; m_slave_id = '0; m_done = '0; slave_busy = '0;
    #1 rstn = 1'b0;
    tick(); tick();
    check("reset_outputs", dut_vec(), 32'h0);
    rstn = 1'b1;

    // Master 0 to slave 1: frame 1,0,1 then grant five edges after sampling.
    m_slave_id = 6'b00_00_01; m_req = 3'b001;
    tick(); check("d1_cur", 32'(cur_master), 32'd0);
    tick(); check("d1_cmd_start", 32'(arbiter_cmd_out), 32'd1);
    tick(); check("d1_cmd_msb", 32'(arbiter_cmd_out), 32'd0);
    tick(); check("d1_cmd_lsb", 32'(arbiter_cmd_out), 32'd1);
    tick(); check("d1_no_grant_yet", 32'(m_grant), 32'd0);
    tick(); check("d1_grant", 32'({m_grant, bus_util}), 32'b0011);
    m_done = 3'b001;
    tick(); check("d1_done_release", 32'({m_grant, bus_util}), 32'd0);
    m_done = '0; m_req = '0;
    tick(); tick(); tick();

    // Invalid ID: immediate reject, no frame.
    m_slave_id = 6'b00_00_11; m_req = 3'b001;
    tick(); check("d2_reject", 32'({reject_pulse, arbiter_cmd_out}), 32'b10);
    m_req = '0;
    tick(); check("d2_reject_one_cycle", 32'(reject_pulse), 32'd0);
    tick();

    // Master 1 to busy slave 2: frame 1,1,0, reject after CHECK.
    m_slave_id = 6'b00_10_00; slave_busy = 3'b100; m_req = 3'b010;
    tick(); check("d3_cur", 32'(cur_master), 32'd1);
    tick(); check("d3_cmd_start", 32'(arbiter_cmd_out), 32'd1);
    tick(); check("d3_cmd_msb", 32'(arbiter_cmd_out), 32'd1);
    tick(); check("d3_cmd_lsb", 32'(arbiter_cmd_out), 32'd0);
    tick(); check("d3_reject", 32'({m_grant, reject_pulse}), 32'b0001);
    m_req = 3'b111; m_slave_id = '0; slave_busy = '0;
    tick(); check("d3_next_from_m2", 32'(cur_master), 32'd2);
    m_req = '0;
    repeat (6) tick();

    // Timeout: grant held eight cycles, then pulse with bus idle.
    m_slave_id = '0; m_req = 3'b001; cnt = 0; n = 0;
    while (m_grant == 3'b000 && n < 20) begin tick(); n++; end
    while (m_grant != 3'b000 && n < 40) begin cnt++; tick(); n++; end
    check("d4_grant_len", cnt, 32'd8);
    check("d4_timeout_pulse", 32'({timeout_pulse, bus_util}), 32'b10);
    m_req = '0;
    tick(); check("d4_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
    tick();

    // Done in the last allowed cycle wins over timeout.
    m_req = 3'b001; cnt = 0; n = 0;
    while (m_grant == 3'b000 && n < 20) begin tick(); n++; end
    while (m_grant != 3'b000 && n < 40) begin
      cnt++;
      if (cnt == 8) m_done = 3'b001;
      tick(); n++;
    end
    check("d5_grant_len", cnt, 32'd8);
    check("d5_no_timeout", 32'({timeout_pulse, bus_util}), 32'b00);
    m_done = '0; m_req = '0;
    tick(); tick();

    // Asynchronous reset in the middle of a frame.
    m_slave_id = 6'b00_01_00; m_req = 3'b010;
    tick(); tick();
    check("a1_mid_send", 32'({arbiter_cmd_out, cur_master}), 32'b101);
    #2 rstn = 1'b0;
    #1 check("a1_async_zero", dut_vec(), 32'h0);
    m_req = '0;
    tick(); rstn = 1'b1;
    tick();

    // Asynchronous reset while granted.
    m_req = 3'b010;
    repeat (6) tick();
    check("a2_mid_grant", 32'(m_grant), 32'b010);
    #2 rstn = 1'b0;
    #1 check("a2_async_zero", dut_vec(), 32'h0);
    m_req = 3'b111; m_slave_id = 6'b10_01_00; slave_busy = '0;
    tick(); rstn = 1'b1;

    // Fair rotation with all masters requesting, four grant cycles each.
    for (int k = 0; k < 4; k++) order[k] = '0;
    ng = 0; gcnt = 0; prev_g = '0;
    for (int c = 0; c < 200 && ng < 4; c++) begin
      tick();
      if (m_grant != 3'b000) begin
        gcnt++;
        if (prev_g == 3'b000) begin
          order[ng] = m_grant;
          ng++;
        end
      end else begin
        gcnt = 0;
      end
      prev_g = m_grant;
      m_done = (gcnt == 4) ? m_grant : 3'b000;
    end
    check("rr_grant0", 32'(order[0]), 32'b001);
    check("rr_grant1", 32'(order[1]), 32'b010);
    check("rr_grant2", 32'(order[2]), 32'b100);
    check("rr_grant3", 32'(order[3]), 32'b001);
    m_req = '0; m_done = '0;
    repeat (4) tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 7) == 0) m_req[b] = ~m_req[b];
      end
      if ($urandom_range(0, 3) == 0) m_slave_id = 6'($urandom);
      slave_busy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      m_done     = ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'b000;
    end
    m_req = '0; m_done = '0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, 3, number of requesting masters (fixed at 3).
REQ-002 Parameter NUM_SLAVES, 3, number of valid slave IDs (0..NUM_SLAVES-1).
REQ-003 Parameter SLAVE_ID_WIDTH, 2, bits per slave ID.
REQ-004 Parameter TIMEOUT, 8'd255, maximum GRANT duration in clk cycles.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 m_req  input  3  per-master bus request, level-held.
REQ-008 m_slave_id  input  6  packed target IDs; bits [2i+1:2i] belong to master i.
REQ-009 m_done  input  3  per-master transfer-complete strobe.
REQ-010 slave_busy  input  3  per-slave busy_out, indexed by slave ID.
REQ-011 m_grant  output  3  one-hot grant; all zero when the bus is not granted.
REQ-012 bus_util  output  1  high while any grant is active.
REQ-013 arbiter_cmd_out  output  1  serial slave-select line, broadcast to all slaves.
REQ-014 cur_master  output  2  index of the latched master; holds its last value when the bus is idle.
REQ-015 timeout_pulse  output  1  one-cycle pulse when a grant is force-ended by timeout.
REQ-016 reject_pulse  output  1  one-cycle pulse when a request is refused (invalid ID or busy slave).

Function
REQ-017 States SHALL be IDLE, SEND, CHECK, GRANT and RELEASE; all outputs SHALL be registered.
REQ-018 IDLE arbitration:
- Round-robin search begins at master (last_served+1) mod 3.
- The first master with m_req=1 is latched into cur_master, together with its m_slave_id.
- last_served resets to 2, so master 0 has first priority after reset.
REQ-019 An ID >= NUM_SLAVES found in IDLE SHALL produce the following, then stay in IDLE:
- pulse reject_pulse;
- set last_served to that master;
- send no frame.
REQ-020 SEND SHALL drive a start bit of 1, then the ID MSB-first on arbiter_cmd_out, one bit per cycle (3 cycles total), then enter CHECK.
REQ-021 arbiter_cmd_out SHALL be 0 in every state except SEND.
REQ-022 CHECK (1 cycle) SHALL take exactly one of these actions:
- m_req[cur]=0: go to IDLE with no grant and no pulse.
- else slave_busy[target]=1: pulse reject_pulse, set last_served=cur, go to IDLE.
- else: go to GRANT.
REQ-023 Latency: with a request sampled in IDLE at edge k, arbiter_cmd_out carries the frame after edges k+1..k+3, and m_grant/bus_util assert after edge k+5.
REQ-024 In GRANT, m_grant[cur]=1 and bus_util=1, and the 8-bit hold counter increments every cycle from 0.
REQ-025 GRANT SHALL exit to RELEASE on any of:
- m_done[cur]=1;
- m_req[cur]=0;
- the counter reaching TIMEOUT-1.
REQ-026 On a timeout exit, timeout_pulse SHALL assert for one cycle; if m_done[cur] is also 1 in that cycle, the exit is a normal release with no timeout_pulse.
REQ-027 RELEASE (1 cycle) SHALL clear m_grant and bus_util, set last_served=cur, and return to IDLE.
REQ-028 A new arbitration SHALL NOT start until the IDLE cycle after RELEASE, giving a minimum one-cycle bus gap.
REQ-029 m_done and requests from non-latched masters SHALL be ignored outside IDLE.
REQ-030 At most one m_grant bit SHALL ever be high.

Reset
REQ-031 rstn low SHALL, immediately and from any state including mid-SEND or mid-GRANT, force:
- state to IDLE;
- m_grant, bus_util, arbiter_cmd_out, timeout_pulse and reject_pulse to 0;
- cur_master to 0;
- the hold counter to 0;
- last_served to 2.
REQ-032 After rstn rises, the first rising edge SHALL perform a normal IDLE arbitration.

Verification
REQ-033 Reset, then m_req=3'b001, id0=2'd1, slave_busy=0:
- arbiter_cmd_out shows 1,0,1;
- m_grant=3'b001 five cycles after sampling;
- m_done[0] pulse -> next cycle grant 0, then IDLE.
REQ-034 m_req=3'b111 held, all IDs valid and idle, each master asserting m_done after 4 grant cycles: grants SHALL occur in order 001,010,100,001.
REQ-035 Master 1 requests ID 2 with slave_busy=3'b100:
- start bit 1, then 1,0 on arbiter_cmd_out;
- reject_pulse in the cycle after CHECK;
- no grant;
- next arbitration starts from master 2.
REQ-036 Master 0 requests ID 3: reject_pulse one cycle after the request is sampled; arbiter_cmd_out stays 0.
REQ-037 Timeout and done handling:
- With TIMEOUT=8 and m_done never asserted, grant SHALL last exactly 8 cycles, then timeout_pulse=1 and bus_util=0.
- With m_done asserted in cycle 8, there SHALL be no timeout_pulse.
REQ-038 Assert rstn=0 mid-GRANT and mid-SEND: all outputs SHALL be 0 asynchronously, before the next clk edge.
